cp0_unit: RTL and testbench

Coprocessor-0 responder for the 5-stage MIPS pipeline. It consumes the `oper` code (NONE / STORE / ERET) and the MFC0 read address that the controller produces in ID/EXE. It holds STATUS, CAUSE and EPC, latches external interrupt requests and decides when to take an interrupt or execute ERET. It drives the `jump_en` / `jump_addr` redirect that the controller and IF stage use to flush and re-steer the pipeline.

---
 rtl/cp0_unit_pkg.sv | 23 ++
 rtl/cp0_irq_latch.sv | 25 ++
 rtl/cp0_unit.sv | 140 ++++++++++++++
 tb/tb_cp0_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: operation codes, register indices,
// STATUS bit positions and the responder FSM encoding.
package cp0_unit_pkg;

  localparam logic [1:0] CP_NONE  = 2'b00;
  localparam logic [1:0] CP_STORE = 2'b01;
  localparam logic [1:0] CP_ERET  = 2'b10;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_IM  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_JUMP   = 2'b01,
    S_SETTLE = 2'b10
  } cp0_state_t;

endpackage

// File: rtl/cp0_irq_latch.sv
// Per-line rising-edge detect feeding sticky pending bits.
// A new edge wins over a same-cycle write-1-to-clear.
module cp0_irq_latch #(
  parameter int IRQ_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_WIDTH-1:0] ir,
  input  logic [IRQ_WIDTH-1:0] clr,
  output logic [IRQ_WIDTH-1:0] ip
);

  logic [IRQ_WIDTH-1:0] ir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
      ip   <= '0;
    end else begin
      ir_q <= ir;
      ip   <= (ip & ~clr) | (ir & ~ir_q);
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: STATUS/CAUSE/EPC, interrupt take
// and ERET, driving a one-cycle pipeline redirect.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter int          IRQ_WIDTH  = 4,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0008
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           oper,
  input  logic                 inst_valid,
  input  logic                 en,
  input  logic [31:0]          ret_addr,
  input  logic [4:0]           addr_r,
  output logic [31:0]          data_r,
  input  logic [4:0]           addr_w,
  input  logic [31:0]          data_w,
  input  logic [IRQ_WIDTH-1:0] ir,
  output logic                 jump_en,
  output logic [31:0]          jump_addr,
  output logic                 exl
);

  cp0_state_t state, state_n;

  logic                 ie;
  logic                 exl_q;
  logic [IRQ_WIDTH-1:0] im;
  logic [IRQ_WIDTH-1:0] ip;
  logic [IRQ_WIDTH-1:0] clr;
  logic [31:0]          epc;

  logic act, fire;
  logic is_st, is_er;
  logic take, eret, store;
  logic unused_bits;

  assign act  = inst_valid & en;
  assign fire = ie & ~exl_q & (|(ip & im)) & act;

  always_comb begin
    is_st = 1'b0;
    is_er = 1'b0;
    unique case (oper)
      CP_STORE: is_st = 1'b1;
      CP_ERET:  is_er = 1'b1;
      CP_NONE:  ;
      default:  ;
    endcase
  end

  // Only S_IDLE makes decisions; the other states drain the wrong path
  always_comb begin
    state_n = state;
    take    = 1'b0;
    eret    = 1'b0;
    store   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fire) begin
          take    = 1'b1;
          state_n = S_JUMP;
        end else if (is_er & act) begin
          eret    = 1'b1;
          state_n = S_JUMP;
        end else if (is_st & act) begin
          store = 1'b1;
        end
      end
      S_JUMP:   state_n = S_SETTLE;
      S_SETTLE: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  assign clr = (store && addr_w == CP0_CAUSE)
             ? data_w[ST_IM +: IRQ_WIDTH] : '0;

  cp0_irq_latch #(
    .IRQ_WIDTH (IRQ_WIDTH)
  ) u_irq (
    .clk (clk),
    .rst (rst),
    .ir  (ir),
    .clr (clr),
    .ip  (ip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie        <= 1'b0;
      exl_q     <= 1'b0;
      im        <= '0;
      epc       <= '0;
      jump_addr <= '0;
    end else if (take) begin
      epc       <= ret_addr;
      exl_q     <= 1'b1;
      jump_addr <= INT_VECTOR;
    end else if (eret) begin
      exl_q     <= 1'b0;
      jump_addr <= epc;
    end else if (store) begin
      if (addr_w == CP0_STATUS) begin
        ie    <= data_w[ST_IE];
        exl_q <= data_w[ST_EXL];
        im    <= data_w[ST_IM +: IRQ_WIDTH];
      end
      if (addr_w == CP0_EPC) epc <= data_w;
    end
  end

  assign jump_en = (state == S_JUMP);
  assign exl     = exl_q;

  always_comb begin
    data_r = '0;
    unique case (1'b1)
      (addr_r == CP0_STATUS): begin
        data_r[ST_IE]              = ie;
        data_r[ST_EXL]             = exl_q;
        data_r[ST_IM +: IRQ_WIDTH] = im;
      end
      (addr_r == CP0_CAUSE):
        data_r[ST_IM +: IRQ_WIDTH] = ip;
      (addr_r == CP0_EPC):
        data_r = epc;
      default: ;
    endcase
  end

  assign unused_bits = &{1'b0, data_w};

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed table, corner
// sequences and randomized traffic against a cycle model.
module tb_cp0_unit;
  import cp0_unit_pkg::*;

  localparam int          W   = 4;
  localparam logic [31:0] VEC = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  oper;
  logic        inst_valid;
  logic        en;
  logic [31:0] ret_addr;
  logic [4:0]  addr_r;
  logic [31:0] data_r;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic [W-1:0] ir;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        exl;

  cp0_unit #(
    .IRQ_WIDTH  (W),
    .INT_VECTOR (VEC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .oper       (oper),
    .inst_valid (inst_valid),
    .en         (en),
    .ret_addr   (ret_addr),
    .addr_r     (addr_r),
    .data_r     (data_r),
    .addr_w     (addr_w),
    .data_w     (data_w),
    .ir         (ir),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .exl        (exl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic iv,
                       input logic [4:0] aw, input logic [31:0] dw,
                       input logic [W-1:0] irv, input logic [4:0] ar,
                       input logic [31:0] ra);
    oper = op; inst_valid = iv; en = 1'b1;
    addr_w = aw; data_w = dw; ir = irv;
    addr_r = ar; ret_addr = ra;
  endtask

  task automatic do_reset;
    drive(CP_NONE, 1'b0, 5'd0, 32'h0, '0, 5'd0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // Reference model: architectural registers plus a decision cooldown
  logic         m_ie, m_exl;
  logic [W-1:0] m_im, m_ip, m_prev;
  logic [31:0]  m_epc, m_ja;
  logic         m_jen;
  int           m_block;

  task automatic m_reset;
    m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_prev = '0;
    m_epc = '0; m_ja = '0; m_jen = 0; m_block = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return {20'b0, m_im, 6'b0, m_exl, m_ie};
      5'd13:   return {20'b0, m_ip, 8'b0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step;
    logic         ok, f, er, st;
    logic [W-1:0] rise, wclr;
    ok = (m_block == 0) && inst_valid && en;
    f  = ok && m_ie && !m_exl && ((m_ip & m_im) != 0);
    er = ok && !f && oper == CP_ERET;
    st = ok && !f && !er && oper == CP_STORE;
    rise = ir & ~m_prev;
    wclr = (st && addr_w == 5'd13) ? data_w[11:8] : '0;
    m_prev = ir;
    if (f) begin
      m_epc = ret_addr; m_exl = 1; m_ja = VEC;
    end else if (er) begin
      m_ja = m_epc; m_exl = 0;
    end else if (st && addr_w == 5'd12) begin
      m_ie = data_w[0]; m_exl = data_w[1]; m_im = data_w[11:8];
    end else if (st && addr_w == 5'd14) begin
      m_epc = data_w;
    end
    m_ip = (m_ip & ~wclr) | rise;
    m_jen = f || er;
    if (f || er) m_block = 2;
    else if (m_block > 0) m_block--;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic         iv;
    logic [4:0]   aw;
    logic [31:0]  dw;
    logic [W-1:0] irv;
    logic [4:0]   ar;
    logic [31:0]  ra;
    logic [31:0]  exp_dr;
    logic         exp_jen;
    logic [31:0]  exp_ja;
    logic         exp_exl;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
      input logic [1:0] op, input logic [4:0] aw,
      input logic [31:0] dw, input logic [W-1:0] irv,
      input logic [4:0] ar, input logic [31:0] ra,
      input logic [31:0] edr, input logic ejen,
      input logic [31:0] eja, input logic eexl);
    vec_t v;
    v.op = op; v.iv = 1'b1; v.aw = aw; v.dw = dw; v.irv = irv;
    v.ar = ar; v.ra = ra; v.exp_dr = edr; v.exp_jen = ejen;
    v.exp_ja = eja; v.exp_exl = eexl;
    return v;
  endfunction

  initial begin
    rst = 1'b0;
    m_reset();
    do_reset();

    chk("rst_jen", {31'b0, jump_en}, 32'h0);
    chk("rst_jaddr", jump_addr, 32'h0);
    chk("rst_exl", {31'b0, exl}, 32'h0);

    // Directed table: MTC0/MFC0, take, W1C + ERET, masking
    tbl[0]  = mk(CP_STORE, 12, 32'hF01, 4'b0000, 12, 32'h0,  32'h000, 0, 0, 0);
    tbl[1]  = mk(CP_NONE,  0,  32'h0,   4'b0000, 12, 32'h0,  32'hF01, 0, 0, 0);
    tbl[2]  = mk(CP_STORE, 9,  32'h5,   4'b0000, 12, 32'h0,  32'hF01, 0, 0, 0);
    tbl[3]  = mk(CP_NONE,  0,  32'h0,   4'b0100, 9,  32'h0,  32'h000, 0, 0, 0);
    tbl[4]  = mk(CP_NONE,  0,  32'h0,   4'b0100, 13, 32'h40, 32'h400, 1, 32'h8, 1);
    tbl[5]  = mk(CP_STORE, 14, 32'h123, 4'b0100, 14, 32'h0,  32'h040, 0, 0, 1);
    tbl[6]  = mk(CP_NONE,  0,  32'h0,   4'b0100, 12, 32'h0,  32'hF03, 0, 0, 1);
    tbl[7]  = mk(CP_STORE, 13, 32'h400, 4'b0100, 13, 32'h0,  32'h400, 0, 0, 1);
    tbl[8]  = mk(CP_ERET,  0,  32'h0,   4'b0100, 13, 32'h0,  32'h000, 1, 32'h40, 0);
    tbl[9]  = mk(CP_NONE,  0,  32'h0,   4'b0100, 12, 32'h0,  32'hF01, 0, 0, 0);
    tbl[10] = mk(CP_NONE,  0,  32'h0,   4'b0100, 14, 32'h0,  32'h040, 0, 0, 0);
    tbl[11] = mk(CP_STORE, 12, 32'h001, 4'b0000, 12, 32'h0,  32'hF01, 0, 0, 0);
    tbl[12] = mk(CP_NONE,  0,  32'h0,   4'b0001, 13, 32'h0,  32'h000, 0, 0, 0);
    tbl[13] = mk(CP_NONE,  0,  32'h0,   4'b0001, 13, 32'h0,  32'h100, 0, 0, 0);
    tbl[14] = mk(CP_STORE, 12, 32'hF01, 4'b0001, 12, 32'h0,  32'h001, 0, 0, 0);
    tbl[15] = mk(CP_NONE,  0,  32'h0,   4'b0001, 12, 32'h80, 32'hF01, 1, 32'h8, 1);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].op, tbl[i].iv, tbl[i].aw, tbl[i].dw,
            tbl[i].irv, tbl[i].ar, tbl[i].ra);
      #1;
      chk($sformatf("tbl%0d_data_r", i), data_r, tbl[i].exp_dr);
      tick();
      chk($sformatf("tbl%0d_jen", i), {31'b0, jump_en},
          {31'b0, tbl[i].exp_jen});
      if (tbl[i].exp_jen)
        chk($sformatf("tbl%0d_jaddr", i), jump_addr, tbl[i].exp_ja);
      chk($sformatf("tbl%0d_exl", i), {31'b0, exl},
          {31'b0, tbl[i].exp_exl});
    end

    // Reset in S_JUMP drops the redirect immediately
    do_reset();
    drive(CP_STORE, 1, 12, 32'hF01, 4'b0000, 0, 32'h0); tick();
    drive(CP_NONE,  1, 0,  32'h0,   4'b1000, 0, 32'h0); tick();
    drive(CP_NONE,  1, 0,  32'h0,   4'b1000, 0, 32'h44); tick();
    chk("pre_rst_jen", {31'b0, jump_en}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_jen", {31'b0, jump_en}, 32'h0);
    addr_r = 5'd12; #1 chk("rst_status", data_r, 32'h0);
    addr_r = 5'd13; #1 chk("rst_cause", data_r, 32'h0);
    addr_r = 5'd14; #1 chk("rst_epc", data_r, 32'h0);
    @(negedge clk) rst = 1'b0;
    #1;

    // Collision: MTC0 EPC loses to fire; later IRQ waits for ERET
    drive(CP_STORE, 1, 12, 32'hF01, 4'b0000, 0, 32'h0); tick();
    drive(CP_NONE,  1, 0,  32'h0,   4'b0010, 0, 32'h0); tick();
    drive(CP_STORE, 1, 14, 32'h99,  4'b0010, 0, 32'h200); tick();
    chk("col_jen", {31'b0, jump_en}, 32'h1);
    chk("col_jaddr", jump_addr, VEC);
    drive(CP_NONE, 1, 0, 32'h0, 4'b1010, 0, 32'h0); tick();
    chk("col_jump_end", {31'b0, jump_en}, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("col_hold%0d", i), {31'b0, jump_en}, 32'h0);
    end
    addr_r = 5'd14; #1 chk("col_epc", data_r, 32'h200);
    addr_r = 5'd13; #1 chk("col_cause", data_r, 32'hA00);
    oper = CP_ERET; tick();
    chk("col_eret_jen", {31'b0, jump_en}, 32'h1);
    chk("col_eret_jaddr", jump_addr, 32'h200);
    chk("col_eret_exl", {31'b0, exl}, 32'h0);
    oper = CP_NONE; tick(); tick(); tick();
    chk("col_retake_jen", {31'b0, jump_en}, 32'h1);
    chk("col_retake_jaddr", jump_addr, VEC);

    // Randomized traffic against the model
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      oper = (r < 5) ? CP_NONE : (r < 8) ? CP_STORE : CP_ERET;
      inst_valid = ($urandom_range(0, 7) != 0);
      en = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 4);
      addr_w = (r == 0) ? 5'd12 : (r == 1) ? 5'd13 :
               (r == 2) ? 5'd14 : 5'($urandom);
      data_w = $urandom;
      if ($urandom_range(0, 5) == 0)
        ir = ir ^ W'(1 << $urandom_range(0, W - 1));
      r = $urandom_range(0, 3);
      addr_r = (r == 0) ? 5'd12 : (r == 1) ? 5'd13 :
               (r == 2) ? 5'd14 : 5'($urandom);
      ret_addr = $urandom;
      #1;
      chk("rnd_data_r", data_r, m_read(addr_r));
      m_step();
      tick();
      chk("rnd_jen", {31'b0, jump_en}, {31'b0, m_jen});
      if (m_jen) chk("rnd_jaddr", jump_addr, m_ja);
      chk("rnd_exl", {31'b0, exl}, {31'b0, m_exl});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
